// File: rtl/out_collector_if.sv
// Handshake bundle between the execute stage / host and the output collector.
// Producer side: out_data/out_valid/halt_ex/start in, host side: tx_ready in.
// Collector side: tx_valid/tx_data/tx_last/count/overflow/done out.
interface out_collector_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [2:0]    out_data;
  logic          out_valid;
  logic          halt_ex;
  logic          start;
  logic          tx_ready;
  logic          tx_valid;
  logic [2:0]    tx_data;
  logic          tx_last;
  logic [CW-1:0] count;
  logic          overflow;
  logic          done;

  // master: the environment (execute stage + host) driving the collector
  modport master (
    output out_data, out_valid, halt_ex, start, tx_ready,
    input  tx_valid, tx_data, tx_last, count, overflow, done
  );

  // slave: the collector itself
  modport slave (
    input  out_data, out_valid, halt_ex, start, tx_ready,
    output tx_valid, tx_data, tx_last, count, overflow, done
  );
endinterface

// File: rtl/out_collector.sv
// Output collector: buffers execute-stage output values in a DEPTH-entry FIFO for a host.
// Latency: a value pushed into an empty FIFO is presented one cycle after its push edge (no bypass).
// Backpressure: host stalls with tx_ready=0; a push into a full FIFO without a same-cycle pop is dropped and sets sticky overflow.
// Ports: clk (rising edge), rst_n (async active-low), bus (out_collector_if.slave):
//   in : out_data[2:0], out_valid, halt_ex, start, tx_ready
//   out: tx_valid, tx_data[2:0], tx_last, count, overflow, done
// DEPTH must be a power of two, at least 2 (pointers wrap by natural overflow).
module out_collector #(
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  out_collector_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_done;
  logic [2:0]    r_mem [DEPTH];

  logic          w_active;
  logic          w_tx_vld;
  logic          w_full;
  logic          w_push_req;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_start;
  logic [CW-1:0] w_count_nxt;

  assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_tx_vld   = w_active && (r_count != '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_push_req = (r_state == S_RUN) && bus.out_valid;
  assign w_pop      = w_tx_vld && bus.tx_ready;
  // A full FIFO still accepts a value when the head leaves in the same cycle.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;
  // start only matters between runs; mid-run starts are ignored.
  assign w_start    = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Control FSM with pointers, occupancy and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else if (w_start) begin
      r_state <= S_RUN;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= w_count_nxt;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
      case (r_state)
        S_RUN: begin
          // The push in the halting cycle is already folded into w_push.
          if (bus.halt_ex) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Entering DRAIN with an empty FIFO falls through here one edge later.
          if (w_count_nxt == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Storage carries no reset; tx_data is masked whenever nothing is presented.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.out_data;
    end
  end

  assign bus.tx_valid = w_tx_vld;
  assign bus.tx_data  = w_tx_vld ? r_mem[r_rptr] : 3'd0;
  assign bus.tx_last  = (r_state == S_DRAIN) && (r_count == CW'(1)) && w_tx_vld;
  assign bus.count    = r_count;
  assign bus.overflow = r_ovf;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_out_collector.sv
// Self-checking bench for out_collector: queue-based reference model compared every cycle,
// plus directed runs (basic, overflow, full with pop, empty, backpressure, reset) with literal expectations.
// Clock period 10; inputs change 1 time unit after the falling edge, outputs compared on the falling edge.
module tb_out_collector;
  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  out_collector_if #(.DEPTH(DEPTH)) b();
  out_collector #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mst_t;
  mst_t       ms   = M_IDLE;
  logic [2:0] mq[$];
  bit         movf = 1'b0;
  int         exp_got[$];

  function automatic bit m_vld();
    return ((ms == M_RUN) || (ms == M_DRAIN)) && (mq.size() > 0);
  endfunction

  initial begin
    bit pop;
    bit preq;
    bit full;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        ms   = M_IDLE;
        movf = 1'b0;
      end else if (b.start && ((ms == M_IDLE) || (ms == M_DONE))) begin
        mq.delete();
        exp_got.delete();
        movf = 1'b0;
        ms   = M_RUN;
      end else begin
        pop  = m_vld() && b.tx_ready;
        preq = (ms == M_RUN) && b.out_valid;
        full = (mq.size() == DEPTH);
        if (pop) exp_got.push_back(int'(mq.pop_front()));
        if (preq) begin
          if (!full || pop) mq.push_back(b.out_data);
          else movf = 1'b1;
        end
        if ((ms == M_RUN) && b.halt_ex) ms = M_DRAIN;
        else if ((ms == M_DRAIN) && (mq.size() == 0)) ms = M_DONE;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit         cmp_en = 1'b0;
  initial begin
    bit         ev;
    bit         p_vld;
    logic [2:0] p_dat;
    p_vld = 1'b0;
    p_dat = 3'd0;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        ev = m_vld();
        chk("tx_valid", int'(b.tx_valid), int'(ev));
        chk("tx_data",  int'(b.tx_data),  ev ? int'(mq[0]) : 0);
        chk("tx_last",  int'(b.tx_last),  int'((ms == M_DRAIN) && (mq.size() == 1) && ev));
        chk("count",    int'(b.count),    mq.size());
        chk("overflow", int'(b.overflow), int'(movf));
        chk("done",     int'(b.done),     int'(ms == M_DONE));
        // tx_ready seen now is the one that applied at the edge just past
        if (p_vld && !b.tx_ready && b.tx_valid && rst_n)
          chk("stall_stable", int'(b.tx_data), int'(p_dat));
      end
      p_vld = b.tx_valid;
      p_dat = b.tx_data;
    end
  end

  // ---------------- driver ----------------
  int got[$];
  int lastq[$];
  int vld_seen = 0;

  task automatic cyc(input int d, input int v, input int h, input int s, input int r);
    @(negedge clk);
    #1;
    b.out_data  = 3'(d);
    b.out_valid = (v != 0);
    b.halt_ex   = (h != 0);
    b.start     = (s != 0);
    b.tx_ready  = (r != 0);
    if (s != 0) begin
      got.delete();
      lastq.delete();
      vld_seen = 0;
    end
    if (b.tx_valid) vld_seen++;
    if (b.tx_valid && (r != 0)) begin
      got.push_back(int'(b.tx_data));
      if (b.tx_last) lastq.push_back(int'(b.tx_data));
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (!b.done && n < 60) begin
      cyc(0, 0, 0, 0, 1);
      n++;
    end
    chk({nm, "_done_reached"}, int'(b.done), 1);
  endtask

  task automatic cmp_list(input string nm, input int a[$], input int e[$]);
    chk({nm, "_len"}, a.size(), e.size());
    for (int i = 0; i < a.size() && i < e.size(); i++) chk({nm, "_item"}, a[i], e[i]);
  endtask

  initial begin
    int e[$];
    int sent[$];
    int n;
    int k;
    int v;
    int d;
    b.out_data  = 3'd0;
    b.out_valid = 1'b0;
    b.halt_ex   = 1'b0;
    b.start     = 1'b0;
    b.tx_ready  = 1'b0;
    rst_n       = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_count",    int'(b.count),    0);
    chk("rst_tx_valid", int'(b.tx_valid), 0);
    chk("rst_tx_data",  int'(b.tx_data),  0);
    chk("rst_done",     int'(b.done),     0);
    chk("rst_overflow", int'(b.overflow), 0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // basic run: 4,3,1 with the last push in the halting cycle
    cyc(0, 0, 0, 1, 1);
    cyc(4, 1, 0, 0, 1);
    cyc(3, 1, 0, 0, 1);
    cyc(1, 1, 1, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("basic_done_early", int'(b.done), 0);
    cyc(0, 0, 0, 0, 1);
    chk("basic_done_after_pop", int'(b.done), 1);
    e = '{4, 3, 1};
    cmp_list("basic_lit", got, e);
    cmp_list("basic_model", got, exp_got);
    chk("basic_last_cnt", lastq.size(), 1);
    if (lastq.size() > 0) chk("basic_last_val", lastq[0], 1);

    // overflow: 9 pushes into a stalled FIFO
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) cyc(i % 8, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("ovf_count", int'(b.count), 8);
    chk("ovf_flag",  int'(b.overflow), 1);
    cyc(0, 0, 1, 0, 1);
    drain("ovf");
    e.delete();
    for (int i = 0; i < 8; i++) e.push_back(i);
    cmp_list("ovf_lit", got, e);
    cmp_list("ovf_model", got, exp_got);

    // full FIFO with simultaneous push and pop
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(i, 1, 0, 0, 0);
    cyc(5, 1, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    chk("fullpop_count", int'(b.count), 8);
    chk("fullpop_ovf",   int'(b.overflow), 0);
    drain("fullpop");
    e.delete();
    for (int i = 0; i < 8; i++) e.push_back(i);
    e.push_back(5);
    cmp_list("fullpop_lit", got, e);
    cmp_list("fullpop_model", got, exp_got);
    chk("fullpop_last_cnt", lastq.size(), 1);
    if (lastq.size() > 0) chk("fullpop_last_val", lastq[0], 5);

    // empty run
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("empty_done_1", int'(b.done), 0);
    cyc(0, 0, 0, 0, 1);
    chk("empty_done_2", int'(b.done), 1);
    chk("empty_no_valid", vld_seen, 0);

    // backpressure and pointer wrap: 20 pushes, random tx_ready
    cyc(0, 0, 0, 1, 1);
    sent.delete();
    n = 0;
    k = 0;
    while (n < 20 && k < 400) begin
      v = int'($urandom_range(0, 1));
      d = int'($urandom_range(0, 7));
      cyc(d, v, 0, 0, ($urandom_range(0, 3) != 0) ? 1 : 0);
      if (v != 0) begin
        sent.push_back(d);
        n++;
      end
      k++;
    end
    chk("bp_pushes", n, 20);
    cyc(0, 0, 1, 0, 1);
    drain("bp");
    cmp_list("bp_model", got, exp_got);
    if (!movf) cmp_list("bp_sent", got, sent);

    // reset mid-run with three entries buffered
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(i + 2, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("mrst_count_before", int'(b.count), 3);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    cyc(7, 1, 0, 0, 1);
    chk("mrst_count",    int'(b.count),    0);
    chk("mrst_tx_valid", int'(b.tx_valid), 0);
    chk("mrst_tx_data",  int'(b.tx_data),  0);
    chk("mrst_tx_last",  int'(b.tx_last),  0);
    chk("mrst_done",     int'(b.done),     0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(7, 1, 0, 0, 1);
    chk("mrst_ignored_count", int'(b.count), 0);
    chk("mrst_ignored_valid", int'(b.tx_valid), 0);

    // random runs, checked cycle by cycle against the model
    for (int run = 0; run < 5; run++) begin
      for (int c = 0; c < 300; c++) begin
        cyc(int'($urandom_range(0, 7)),
            int'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0) ? 1 : 0,
            ($urandom_range(0, 9) == 0) ? 1 : 0,
            ($urandom_range(0, 1)));
      end
    end

    cyc(0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
